regfile_access_ctrl: RTL and testbench
======================================

// Module: regfile_access_ctrl
// PURPOSE
//  Sequences the shared 32x8 register file for two clients: the decode stage (read
//  rsrc1/rsrc2) and writeback (write rdst). Round-robin arbitration when both request.
//  Drives the register file's read/write mode line, addresses and write data.
//  Captures read operands into registers so clients never see combinational file data.
//  Sits between decode/writeback and the register file.
// PARAMETERS
//  ADDR_W  5  register address width (32 registers)
//  DATA_W  8  register data width
// PORTS
//  clk       in   1       clock; all state updates on rising edge
//  reset     in   1       synchronous, active-high reset
//  rd_req    in   1       decode read request; held high until rd_ack
//  rd_rsrc1  in   ADDR_W  read address 1; sampled at grant
//  rd_rsrc2  in   ADDR_W  read address 2; sampled at grant
//  rd_ack    out  1       one-cycle pulse: rd_data1/rd_data2 valid
//  rd_data1  out  DATA_W  operand 1; holds until next read completes
//  rd_data2  out  DATA_W  operand 2; holds until next read completes
//  wr_req    in   1       writeback request; held high until wr_ack
//  wr_rdst   in   ADDR_W  write address; sampled at grant
//  wr_data   in   DATA_W  write data; sampled at grant
//  wr_ack    out  1       one-cycle pulse: write committed
//  rf_read   out  1       file mode: 1 = read, 0 = write strobe
//  rf_rsrc1  out  ADDR_W  file read address 1
//  rf_rsrc2  out  ADDR_W  file read address 2
//  rf_rdst   out  ADDR_W  file write address
//  rf_wdata  out  DATA_W  file write data
//  rf_out1   in   DATA_W  file read data 1
//  rf_out2   in   DATA_W  file read data 2
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, rf_read=1, acks 0, all buses 0, last_grant=WR.
//  - rf_read is 1 in every state except WR_STROBE. The file writes whenever rf_read=0.
//  - FSM states: IDLE, RD_ADDR, RD_CAP, WR_SETUP, WR_STROBE, WR_DONE.
//  - IDLE, rd_req only: go to RD_ADDR; latch rd_rsrc1/2 onto rf_rsrc1/2.
//  - IDLE, wr_req only: go to WR_SETUP; latch wr_rdst/wr_data onto rf_rdst/rf_wdata.
//  - IDLE, both requesting: grant the client not in last_grant; update last_grant.
//  - RD_ADDR -> RD_CAP: capture rf_out1/2 into rd_data1/2.
//  - RD_CAP: rd_ack=1. Next state IDLE.
//  - Read latency: grant edge to rd_ack high = 2 cycles.
//  - WR_SETUP: address and data stable with rf_read=1. Next state WR_STROBE.
//  - WR_STROBE: rf_read=0 for exactly one cycle. Next state WR_DONE.
//  - WR_DONE: rf_read=1, wr_ack=1. Next state IDLE.
//  - Write latency: grant edge to wr_ack high = 3 cycles.
//  - Clients drop or replace req on the edge where they sample ack=1. IDLE then samples the
//    new req, so back-to-back ops need no dead cycle beyond IDLE.
//  - Request inputs are ignored outside IDLE. Addresses and data changing mid-op have no effect.
//  - Read and write to the same register pending together: the order is the grant order.
//    There is no forwarding. A read granted first returns the old value.
//  - Reset in any state: next cycle is IDLE with rf_read=1 and no ack.
//  - Reset during WR_STROBE: the file write may already have landed; it is never acknowledged.
//  - A pending read is discarded by reset. The client must re-request.
// CONFIGURATION
//  R0_ZERO_EN defined:
//  - wr_rdst==0 is still granted and sequenced with the WR_SETUP and WR_DONE timing.
//  - rf_read stays 1 during WR_STROBE, so the file is untouched; wr_ack still pulses.
//  - A read of address 0 returns rd_data=0 regardless of rf_out.
//  R0_ZERO_EN undefined: register 0 is an ordinary register.
// TESTING
//  - Reset: hold reset 2 cycles -> rf_read=1, rd_ack=wr_ack=0, rd_data1/2=0, state IDLE.
//  - Read-only: file preloaded r1=10, r3=40; rd_req with rsrc1=1, rsrc2=3 -> rd_ack 2 cycles after
//    grant, rd_data1=10, rd_data2=40; rf_read never 0.
//  - Write-only: wr_req rdst=5, data=0x5A -> rf_read=0 for exactly 1 cycle with rf_rdst=5,
//    rf_wdata=0x5A stable the cycle before. wr_ack follows; a later read of r5 returns 0x5A.
//  - Contention: rd_req and wr_req held continuously, same reg 7 (old 0x11, new 0x22):
//    grants alternate RD, WR, RD, ...; the first read returns 0x11, the next returns 0x22.
//  - Reset mid-op: assert reset in WR_SETUP -> no rf_read=0 cycle, no wr_ack, IDLE next cycle.
//  - R0_ZERO_EN: write 0xFF to r0 -> wr_ack pulses, rf_read stays 1; read r0 -> rd_data1=0.

Source files
------------

// File: rtl/regfile_access_ctrl_if.sv
// Bus bundle between the access controller, its two clients (decode read,
// writeback write) and the shared register file.
interface regfile_access_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  // decode read client
  logic              rd_req;
  logic [ADDR_W-1:0] rd_rsrc1;
  logic [ADDR_W-1:0] rd_rsrc2;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  // writeback client
  logic              wr_req;
  logic [ADDR_W-1:0] wr_rdst;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  // register file side
  logic              rf_read;
  logic [ADDR_W-1:0] rf_rsrc1;
  logic [ADDR_W-1:0] rf_rsrc2;
  logic [ADDR_W-1:0] rf_rdst;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_out1;
  logic [DATA_W-1:0] rf_out2;

  // controller view
  modport slave (
    input  rd_req, rd_rsrc1, rd_rsrc2, wr_req, wr_rdst, wr_data, rf_out1, rf_out2,
    output rd_ack, rd_data1, rd_data2, wr_ack,
           rf_read, rf_rsrc1, rf_rsrc2, rf_rdst, rf_wdata
  );

  // clients + register file view
  modport master (
    output rd_req, rd_rsrc1, rd_rsrc2, wr_req, wr_rdst, wr_data, rf_out1, rf_out2,
    input  rd_ack, rd_data1, rd_data2, wr_ack,
           rf_read, rf_rsrc1, rf_rsrc2, rf_rdst, rf_wdata
  );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Register file access controller: round-robin sequencing of decode reads
// and writeback writes onto a shared 32x8 register file. All outputs are
// registered; read operands are captured so clients never see raw file data.
// Optional feature macro: R0_ZERO_EN (register 0 hardwired to zero).
module regfile_access_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_access_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_CAP,
    WR_SETUP,
    WR_STROBE,
    WR_DONE
  } state_t;

  localparam logic GR_RD = 1'b0;
  localparam logic GR_WR = 1'b1;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              rf_read_q, rf_read_d;
  logic              rd_ack_q, rd_ack_d;
  logic              wr_ack_q, wr_ack_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [ADDR_W-1:0] rsrc1_q, rsrc1_d;
  logic [ADDR_W-1:0] rsrc2_q, rsrc2_d;
  logic [ADDR_W-1:0] rdst_q, rdst_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              grant_rd, grant_wr;

  // Next-state, arbitration and next-output values
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    rf_read_d = 1'b1;
    rd_ack_d  = 1'b0;
    wr_ack_d  = 1'b0;
    rd1_d     = rd1_q;
    rd2_d     = rd2_q;
    rsrc1_d   = rsrc1_q;
    rsrc2_d   = rsrc2_q;
    rdst_d    = rdst_q;
    wdata_d   = wdata_q;
    grant_rd  = 1'b0;
    grant_wr  = 1'b0;
    case (state_q)
      IDLE: begin
        // on contention the client that did not win last time goes first
        grant_rd = bus.rd_req && (!bus.wr_req || last_q == GR_WR);
        grant_wr = bus.wr_req && !grant_rd;
        if (grant_rd) begin
          state_d = RD_ADDR;
          last_d  = GR_RD;
          rsrc1_d = bus.rd_rsrc1;
          rsrc2_d = bus.rd_rsrc2;
        end else if (grant_wr) begin
          state_d = WR_SETUP;
          last_d  = GR_WR;
          rdst_d  = bus.wr_rdst;
          wdata_d = bus.wr_data;
        end
      end
      RD_ADDR: begin
        // file addresses have been stable a full cycle; capture operands
        state_d  = RD_CAP;
        rd_ack_d = 1'b1;
`ifdef R0_ZERO_EN
        rd1_d = (rsrc1_q == '0) ? '0 : bus.rf_out1;
        rd2_d = (rsrc2_q == '0) ? '0 : bus.rf_out2;
`else
        rd1_d = bus.rf_out1;
        rd2_d = bus.rf_out2;
`endif
      end
      RD_CAP:   state_d = IDLE;
      WR_SETUP: begin
        state_d = WR_STROBE;
`ifdef R0_ZERO_EN
        // writes to r0 keep the normal timing but never strobe the file
        rf_read_d = (rdst_q == '0);
`else
        rf_read_d = 1'b0;
`endif
      end
      WR_STROBE: begin
        state_d  = WR_DONE;
        wr_ack_d = 1'b1;
      end
      WR_DONE:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops any in-flight operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= GR_WR;
      rf_read_q <= 1'b1;
      rd_ack_q  <= 1'b0;
      wr_ack_q  <= 1'b0;
      rd1_q     <= '0;
      rd2_q     <= '0;
      rsrc1_q   <= '0;
      rsrc2_q   <= '0;
      rdst_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      rf_read_q <= rf_read_d;
      rd_ack_q  <= rd_ack_d;
      wr_ack_q  <= wr_ack_d;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
      rsrc1_q   <= rsrc1_d;
      rsrc2_q   <= rsrc2_d;
      rdst_q    <= rdst_d;
      wdata_q   <= wdata_d;
    end
  end

  assign bus.rd_ack   = rd_ack_q;
  assign bus.rd_data1 = rd1_q;
  assign bus.rd_data2 = rd2_q;
  assign bus.wr_ack   = wr_ack_q;
  assign bus.rf_read  = rf_read_q;
  assign bus.rf_rsrc1 = rsrc1_q;
  assign bus.rf_rsrc2 = rsrc2_q;
  assign bus.rf_rdst  = rdst_q;
  assign bus.rf_wdata = wdata_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a behavioural 32x8 register file.
module tb_regfile_access_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   fails = 0;

  regfile_access_ctrl_if #(.ADDR_W(5), .DATA_W(8)) bus ();

  regfile_access_ctrl #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // register file model: combinational read, write on any rf_read=0 cycle
  logic [7:0] mem [32];
  logic       pl_en;
  logic [4:0] pl_addr;
  logic [7:0] pl_data;
  assign bus.rf_out1 = mem[bus.rf_rsrc1];
  assign bus.rf_out2 = mem[bus.rf_rsrc2];
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.rf_read === 1'b0) mem[bus.rf_rdst] <= bus.rf_wdata;
  end

  // strobe / ack monitor
  int         strobe_cnt = 0;
  int         wr_ack_cnt = 0;
  logic       prev_read, pre_read;
  logic [4:0] prev_rdst, pre_rdst, strb_rdst;
  logic [7:0] prev_wdata, pre_wdata, strb_wdata;
  always @(posedge clk) begin
    if (bus.rf_read === 1'b0) begin
      strobe_cnt <= strobe_cnt + 1;
      strb_rdst  <= bus.rf_rdst;
      strb_wdata <= bus.rf_wdata;
      pre_read   <= prev_read;
      pre_rdst   <= prev_rdst;
      pre_wdata  <= prev_wdata;
    end
    if (bus.wr_ack === 1'b1) wr_ack_cnt <= wr_ack_cnt + 1;
    prev_read  <= bus.rf_read;
    prev_rdst  <= bus.rf_rdst;
    prev_wdata <= bus.rf_wdata;
  end

  task automatic preload(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // issue one read; cyc = negedges from request until rd_ack seen (bounded)
  task automatic do_read(input logic [4:0] a1, input logic [4:0] a2,
                         output logic [7:0] d1, output logic [7:0] d2, output int cyc);
    @(negedge clk);
    bus.rd_req = 1'b1; bus.rd_rsrc1 = a1; bus.rd_rsrc2 = a2;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.rd_ack !== 1'b1 && cyc < 20);
    d1 = bus.rd_data1;
    d2 = bus.rd_data2;
    bus.rd_req = 1'b0; bus.rd_rsrc1 = 5'h1f; bus.rd_rsrc2 = 5'h1f;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d, output int cyc);
    @(negedge clk);
    bus.wr_req = 1'b1; bus.wr_rdst = a; bus.wr_data = d;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.wr_ack !== 1'b1 && cyc < 20);
    bus.wr_req = 1'b0; bus.wr_rdst = 5'h1e; bus.wr_data = 8'hee;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.rf_read !== 1'b1) begin fails++; $display("FAIL reset_rf_read got %b exp 1", bus.rf_read); end
    tests_run++;
    if (bus.rd_ack !== 1'b0 || bus.wr_ack !== 1'b0) begin
      fails++; $display("FAIL reset_acks got rd=%b wr=%b exp 0/0", bus.rd_ack, bus.wr_ack);
    end
    tests_run++;
    if ({bus.rd_data1, bus.rd_data2} !== 16'h0) begin
      fails++; $display("FAIL reset_rd_data got %h %h exp 00 00", bus.rd_data1, bus.rd_data2);
    end
    tests_run++;
    if ({bus.rf_rsrc1, bus.rf_rsrc2, bus.rf_rdst, bus.rf_wdata} !== 23'h0) begin
      fails++; $display("FAIL reset_buses got %h %h %h %h exp 0", bus.rf_rsrc1, bus.rf_rsrc2, bus.rf_rdst, bus.rf_wdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_read;
    logic [7:0] d1, d2;
    int cyc, s0;
    preload(5'd1, 8'd10);
    preload(5'd3, 8'd40);
    s0 = strobe_cnt;
    do_read(5'd1, 5'd3, d1, d2, cyc);
    tests_run++;
    if (cyc != 2) begin fails++; $display("FAIL read_latency got %0d exp 2", cyc); end
    tests_run++;
    if (d1 !== 8'd10 || d2 !== 8'd40) begin fails++; $display("FAIL read_data got %0d %0d exp 10 40", d1, d2); end
    @(negedge clk);
    tests_run++;
    if (bus.rd_ack !== 1'b0) begin fails++; $display("FAIL read_ack_pulse got %b exp 0", bus.rd_ack); end
    tests_run++;
    if (bus.rd_data1 !== 8'd10 || bus.rd_data2 !== 8'd40) begin
      fails++; $display("FAIL read_data_hold got %0d %0d exp 10 40", bus.rd_data1, bus.rd_data2);
    end
    tests_run++;
    if (strobe_cnt != s0) begin fails++; $display("FAIL read_no_strobe got %0d exp 0", strobe_cnt - s0); end
  endtask

  task automatic test_write;
    logic [7:0] d1, d2;
    int cyc, s0;
    s0 = strobe_cnt;
    do_write(5'd5, 8'h5A, cyc);
    tests_run++;
    if (cyc != 3) begin fails++; $display("FAIL write_latency got %0d exp 3", cyc); end
    tests_run++;
    if (strobe_cnt - s0 != 1) begin fails++; $display("FAIL write_strobe_count got %0d exp 1", strobe_cnt - s0); end
    tests_run++;
    if (strb_rdst !== 5'd5 || strb_wdata !== 8'h5A) begin
      fails++; $display("FAIL write_strobe_bus got %0d %h exp 5 5a", strb_rdst, strb_wdata);
    end
    tests_run++;
    if (pre_read !== 1'b1 || pre_rdst !== 5'd5 || pre_wdata !== 8'h5A) begin
      fails++; $display("FAIL write_setup got rf_read=%b %0d %h exp 1 5 5a", pre_read, pre_rdst, pre_wdata);
    end
    @(negedge clk);
    tests_run++;
    if (bus.wr_ack !== 1'b0) begin fails++; $display("FAIL write_ack_pulse got %b exp 0", bus.wr_ack); end
    do_read(5'd5, 5'd1, d1, d2, cyc);
    tests_run++;
    if (d1 !== 8'h5A || d2 !== 8'd10) begin fails++; $display("FAIL write_readback got %h %0d exp 5a 10", d1, d2); end
  endtask

  task automatic test_reset_midop;
    logic [7:0] d1, d2;
    int cyc, s0, a0;
    @(negedge clk);
    bus.wr_req = 1'b1; bus.wr_rdst = 5'd9; bus.wr_data = 8'h33;
    @(negedge clk);              // now in WR_SETUP
    s0 = strobe_cnt; a0 = wr_ack_cnt;
    reset = 1'b1; bus.wr_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.rf_read !== 1'b1 || bus.wr_ack !== 1'b0) begin
      fails++; $display("FAIL midop_reset_out got rf_read=%b wr_ack=%b exp 1 0", bus.rf_read, bus.wr_ack);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (strobe_cnt != s0 || wr_ack_cnt != a0) begin
      fails++; $display("FAIL midop_no_write got strobes=%0d acks=%0d exp 0 0", strobe_cnt - s0, wr_ack_cnt - a0);
    end
    do_read(5'd1, 5'd5, d1, d2, cyc);
    tests_run++;
    if (cyc != 2 || d1 !== 8'd10 || d2 !== 8'h5A) begin
      fails++; $display("FAIL midop_idle_after got lat=%0d %0d %h exp 2 10 5a", cyc, d1, d2);
    end
  endtask

  task automatic test_contention;
    int         kind [4];
    logic [7:0] data [4];
    int n, k;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    preload(5'd7, 8'h11);
    @(negedge clk);
    bus.rd_req = 1'b1; bus.rd_rsrc1 = 5'd7; bus.rd_rsrc2 = 5'd7;
    bus.wr_req = 1'b1; bus.wr_rdst = 5'd7; bus.wr_data = 8'h22;
    n = 0; k = 0;
    while (n < 4 && k < 40) begin
      @(negedge clk);
      k++;
      if (bus.rd_ack === 1'b1) begin kind[n] = 0; data[n] = bus.rd_data1; n++; end
      else if (bus.wr_ack === 1'b1) begin kind[n] = 1; data[n] = 8'h00; n++; end
    end
    bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    tests_run++;
    if (n != 4) begin
      fails++; $display("FAIL contention_events got %0d exp 4", n);
    end else begin
      tests_run++;
      if (kind[0] != 0 || kind[1] != 1 || kind[2] != 0 || kind[3] != 1) begin
        fails++; $display("FAIL contention_order got %0d%0d%0d%0d exp 0101", kind[0], kind[1], kind[2], kind[3]);
      end
      tests_run++;
      if (data[0] !== 8'h11) begin fails++; $display("FAIL contention_old got %h exp 11", data[0]); end
      tests_run++;
      if (data[2] !== 8'h22) begin fails++; $display("FAIL contention_new got %h exp 22", data[2]); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_r0;
    logic [7:0] d1, d2;
    int cyc, s0;
    preload(5'd0, 8'h77);
    s0 = strobe_cnt;
    do_write(5'd0, 8'hFF, cyc);
    tests_run++;
    if (cyc != 3) begin fails++; $display("FAIL r0_write_ack got lat=%0d exp 3", cyc); end
    do_read(5'd0, 5'd7, d1, d2, cyc);
`ifdef R0_ZERO_EN
    tests_run++;
    if (strobe_cnt != s0) begin fails++; $display("FAIL r0_no_strobe got %0d exp 0", strobe_cnt - s0); end
    tests_run++;
    if (d1 !== 8'h00 || d2 !== 8'h22) begin fails++; $display("FAIL r0_read got %h %h exp 00 22", d1, d2); end
`else
    tests_run++;
    if (strobe_cnt - s0 != 1) begin fails++; $display("FAIL r0_strobe got %0d exp 1", strobe_cnt - s0); end
    tests_run++;
    if (d1 !== 8'hFF || d2 !== 8'h22) begin fails++; $display("FAIL r0_read got %h %h exp ff 22", d1, d2); end
`endif
  endtask

  initial begin
    reset = 1'b1;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.rd_req = 1'b0; bus.rd_rsrc1 = '0; bus.rd_rsrc2 = '0;
    bus.wr_req = 1'b0; bus.wr_rdst = '0; bus.wr_data = '0;
    test_reset;
    test_read;
    test_write;
    test_reset_midop;
    test_contention;
    test_r0;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
